id_ctrl_pipe: RTL and testbench

//  Next-generation ID-stage control: decodes the 6-bit opcode into the control bundle and

---
 rtl/id_ctrl_pkg.sv | 32 +++
 rtl/id_ctrl_decode.sv | 59 +++++
 rtl/id_ctrl_pipe.sv | 121 ++++++++++++
 tb/tb_id_ctrl_pipe.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ctrl_pkg.sv
// Shared opcode, ALUOp and control-bundle definitions
// for the ID-stage control pipeline.
package id_ctrl_pkg;

  localparam int OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_R    = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_BNE  = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic       regDst;
    logic       regWrite;
    logic [1:0] aluOp;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       branch;
    logic       aluSrc;
    logic       branchNe;
    logic       jump;
  } ctrl_t;

endpackage

// File: rtl/id_ctrl_decode.sv
// Opcode to control-bundle decoder, purely combinational.
// Unknown opcodes yield an all-zero bundle and raise illegal.
module id_ctrl_decode
  import id_ctrl_pkg::*;
#(
  parameter int OP_W   = 6,
  parameter bit EXT_EN = 1'b1
) (
  input  logic [OP_W-1:0] op,
  output ctrl_t           ctrl,
  output logic            usesRt,
  output logic            illegal
);

  always_comb begin
    ctrl    = '0;
    usesRt  = 1'b0;
    illegal = 1'b0;
    unique case (1'b1)
      (op == OP_W'(OP_R)): begin
        ctrl.regDst   = 1'b1;
        ctrl.regWrite = 1'b1;
        ctrl.aluOp    = ALU_FUNCT;
        usesRt        = 1'b1;
      end
      (op == OP_W'(OP_LW)): begin
        ctrl.regWrite = 1'b1;
        ctrl.memRead  = 1'b1;
        ctrl.memToReg = 1'b1;
        ctrl.aluSrc   = 1'b1;
      end
      (op == OP_W'(OP_SW)): begin
        ctrl.memWrite = 1'b1;
        ctrl.aluSrc   = 1'b1;
        usesRt        = 1'b1;
      end
      (op == OP_W'(OP_BEQ)): begin
        ctrl.aluOp  = ALU_SUB;
        ctrl.branch = 1'b1;
        usesRt      = 1'b1;
      end
      (EXT_EN && op == OP_W'(OP_ADDI)): begin
        ctrl.regWrite = 1'b1;
        ctrl.aluSrc   = 1'b1;
      end
      (EXT_EN && op == OP_W'(OP_BNE)): begin
        ctrl.aluOp    = ALU_SUB;
        ctrl.branch   = 1'b1;
        ctrl.branchNe = 1'b1;
        usesRt        = 1'b1;
      end
      (EXT_EN && op == OP_W'(OP_J)): begin
        ctrl.jump = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ctrl_pipe.sv
// ID stage control: decode, load-use hazard, flush and
// valid/ready handshake into the ID/EX register.
module id_ctrl_pipe
  import id_ctrl_pkg::*;
#(
  parameter int OP_W   = 6,
  parameter int RA_W   = 5,
  parameter bit EXT_EN = 1'b1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [RA_W-1:0]  in_rs,
  input  logic [RA_W-1:0]  in_rt,
  input  logic [RA_W-1:0]  in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_reg_dst,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_mem_to_reg,
  output logic             out_branch,
  output logic             out_branch_ne,
  output logic             out_jump,
  output logic             out_alu_src,
  output logic [1:0]       out_alu_op,
  output logic [RA_W-1:0]  out_dest,
  output logic [RA_W-1:0]  out_rs,
  output logic [RA_W-1:0]  out_rt,
  output logic             stall,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  ctrl_t           decCtrl;
  logic            decUsesRt;
  logic            decIllegal;
  logic [RA_W-1:0] decDest;

  logic            validQ;
  ctrl_t           ctrlQ;
  logic [RA_W-1:0] destQ;
  logic [RA_W-1:0] rsQ;
  logic [RA_W-1:0] rtQ;
  logic            illegalQ;
  logic [CNT_W-1:0] cntQ;

  logic hazard;
  logic canLoad;
  logic accept;

  id_ctrl_decode #(
    .OP_W  (OP_W),
    .EXT_EN(EXT_EN)
  ) u_decode (
    .op     (in_op),
    .ctrl   (decCtrl),
    .usesRt (decUsesRt),
    .illegal(decIllegal)
  );

  assign decDest = !decCtrl.regWrite ? '0 :
                   decCtrl.regDst ? in_rd : in_rt;

  assign hazard = in_valid && validQ && ctrlQ.memRead &&
                  (destQ != '0) &&
                  ((destQ == in_rs) ||
                   (decUsesRt && destQ == in_rt));

  assign canLoad  = !validQ || out_ready;
  assign in_ready = canLoad && !hazard && !flush && !rst;
  assign accept   = in_valid && in_ready;
  assign stall    = hazard && !flush;

  // Non-accepting loads clear the bundle so bubbles carry no stale controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      validQ   <= 1'b0;
      ctrlQ    <= '0;
      destQ    <= '0;
      rsQ      <= '0;
      rtQ      <= '0;
      illegalQ <= 1'b0;
      cntQ     <= '0;
    end else begin
      illegalQ <= accept && decIllegal;
      if (accept && decIllegal && cntQ != {CNT_W{1'b1}})
        cntQ <= cntQ + CNT_W'(1);
      if (canLoad || flush) begin
        validQ <= accept;
        ctrlQ  <= accept ? decCtrl : '0;
        destQ  <= accept ? decDest : '0;
        rsQ    <= accept ? in_rs : '0;
        rtQ    <= accept ? in_rt : '0;
      end
    end
  end

  assign out_valid      = validQ;
  assign out_reg_dst    = ctrlQ.regDst;
  assign out_reg_write  = ctrlQ.regWrite;
  assign out_alu_op     = ctrlQ.aluOp;
  assign out_mem_read   = ctrlQ.memRead;
  assign out_mem_write  = ctrlQ.memWrite;
  assign out_mem_to_reg = ctrlQ.memToReg;
  assign out_branch     = ctrlQ.branch;
  assign out_alu_src    = ctrlQ.aluSrc;
  assign out_branch_ne  = ctrlQ.branchNe;
  assign out_jump       = ctrlQ.jump;
  assign out_dest       = destQ;
  assign out_rs         = rsQ;
  assign out_rt         = rtQ;
  assign illegal        = illegalQ;
  assign illegal_cnt    = cntQ;

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Bench for id_ctrl_pipe: two instances (ext set on / off)
// run against a cycle-level reference model.
module tb_id_ctrl_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [1:0] flushI, inValidI, outReadyI;
  logic [1:0][5:0] opI;
  logic [1:0][4:0] rsI, rtI, rdI;

  logic [1:0] inReadyO, outValidO, stallO, illO;
  logic [1:0][10:0] ctrlO;
  logic [1:0][4:0] destO, oRsO, oRtO;
  logic [1:0][7:0] cntO;

  for (genvar g = 0; g < 2; g++) begin : gDut
    logic rdst, rw, mr, mw, m2r, br, bne, jmp, asrc;
    logic [1:0] aop;
    logic ir, ov, st, il;
    logic [4:0] dst, ors, ort;
    logic [7:0] cnt;
    id_ctrl_pipe #(
      .OP_W(6), .RA_W(5), .EXT_EN(g == 1), .CNT_W(8)
    ) u_dut (
      .clk(clk), .rst(rst), .flush(flushI[g]),
      .in_valid(inValidI[g]), .in_ready(ir),
      .in_op(opI[g]), .in_rs(rsI[g]),
      .in_rt(rtI[g]), .in_rd(rdI[g]),
      .out_valid(ov), .out_ready(outReadyI[g]),
      .out_reg_dst(rdst), .out_reg_write(rw),
      .out_mem_read(mr), .out_mem_write(mw),
      .out_mem_to_reg(m2r), .out_branch(br),
      .out_branch_ne(bne), .out_jump(jmp),
      .out_alu_src(asrc), .out_alu_op(aop),
      .out_dest(dst), .out_rs(ors), .out_rt(ort),
      .stall(st), .illegal(il), .illegal_cnt(cnt)
    );
    assign inReadyO[g]  = ir;
    assign outValidO[g] = ov;
    assign stallO[g]    = st;
    assign illO[g]      = il;
    assign ctrlO[g]     = {rdst, rw, aop, mr, mw, m2r, br, asrc, bne, jmp};
    assign destO[g]     = dst;
    assign oRsO[g]      = ors;
    assign oRtO[g]      = ort;
    assign cntO[g]      = cnt;
  end

  typedef struct packed {
    bit        v;
    bit        z;
    bit [10:0] c;
    bit [4:0]  d;
    bit [4:0]  rs;
    bit [4:0]  rt;
    bit        il;
    bit [7:0]  cnt;
  } mst_t;

  mst_t m[2];
  bit   known = 1'b0;
  bit   lastAcc[2];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {illegal, usesRt, regDst..aluSrc, branchNe, jump}
  function automatic bit [12:0] refDec(bit [5:0] op, bit ext);
    bit [8:0] row;
    bit ne, j, urt, ill;
    row = '0; ne = 0; j = 0; urt = 0; ill = 0;
    case (op)
      6'b000000: begin row = 9'b1_1_10_0_0_0_0_0; urt = 1; end
      6'b100011: row = 9'b0_1_00_1_0_1_0_1;
      6'b101011: begin row = 9'b0_0_00_0_1_0_0_1; urt = 1; end
      6'b000100: begin row = 9'b0_0_01_0_0_0_1_0; urt = 1; end
      6'b001000: if (ext) row = 9'b0_1_00_0_0_0_0_1; else ill = 1;
      6'b000101:
        if (ext) begin
          row = 9'b0_0_01_0_0_0_1_0; ne = 1; urt = 1;
        end else ill = 1;
      6'b000010: if (ext) j = 1; else ill = 1;
      default: ill = 1;
    endcase
    return {ill, urt, row, ne, j};
  endfunction

  task automatic tick();
    mst_t nx[2];
    #1;
    for (int i = 0; i < 2; i++) begin
      bit [12:0] dec;
      bit haz, rdy, acc;
      string p;
      p = $sformatf("u%0d", i);
      dec = refDec(opI[i], i == 1);
      haz = inValidI[i] && m[i].v && m[i].c[6] && m[i].d != 0 &&
            (m[i].d == rsI[i] || (dec[11] && m[i].d == rtI[i]));
      rdy = (!m[i].v || outReadyI[i]) && !haz && !flushI[i] && !rst;
      acc = inValidI[i] && rdy;
      if (known) begin
        check({p, ".in_ready"}, 32'(inReadyO[i]), 32'(rdy));
        check({p, ".stall"}, 32'(stallO[i]), 32'(haz && !flushI[i]));
        check({p, ".out_valid"}, 32'(outValidO[i]), 32'(m[i].v));
        check({p, ".illegal"}, 32'(illO[i]), 32'(m[i].il));
        check({p, ".illegal_cnt"}, 32'(cntO[i]), 32'(m[i].cnt));
        if (m[i].v || m[i].z) begin
          check({p, ".ctrl"}, 32'(ctrlO[i]), 32'(m[i].c));
          check({p, ".dest"}, 32'(destO[i]), 32'(m[i].d));
          check({p, ".rs"}, 32'(oRsO[i]), 32'(m[i].rs));
          check({p, ".rt"}, 32'(oRtO[i]), 32'(m[i].rt));
        end
      end
      nx[i] = m[i];
      if (rst) begin
        nx[i] = '0;
        nx[i].z = 1;
      end else begin
        nx[i].il = acc && dec[12];
        if (acc && dec[12] && m[i].cnt != 8'd255)
          nx[i].cnt = m[i].cnt + 8'd1;
        if (flushI[i] || !m[i].v || outReadyI[i]) begin
          nx[i].v = acc;
          nx[i].z = 0;
          if (acc) begin
            nx[i].c  = dec[10:0];
            nx[i].d  = !dec[9] ? 5'd0 : dec[10] ? rdI[i] : rtI[i];
            nx[i].rs = rsI[i];
            nx[i].rt = rtI[i];
          end
        end
      end
      lastAcc[i] = acc;
    end
    @(posedge clk);
    m[0] = nx[0];
    m[1] = nx[1];
    known = 1'b1;
    @(negedge clk);
  endtask

  task automatic setIns(int i, bit v, bit [5:0] op,
                        bit [4:0] rs, bit [4:0] rt, bit [4:0] rd);
    inValidI[i] = v;
    opI[i] = op;
    rsI[i] = rs;
    rtI[i] = rt;
    rdI[i] = rd;
  endtask

  // Upstream holds the instruction until it is accepted.
  task automatic send(int i, bit [5:0] op,
                      bit [4:0] rs, bit [4:0] rt, bit [4:0] rd);
    setIns(i, 1, op, rs, rt, rd);
    tick();
    for (int k = 0; k < 20 && !lastAcc[i]; k++) tick();
    inValidI[i] = 1'b0;
  endtask

  bit [5:0] legalOps[7] = '{6'b000000, 6'b100011, 6'b101011,
                            6'b000100, 6'b001000, 6'b000101, 6'b000010};

  initial begin
    rst = 1'b1;
    flushI = '0;
    outReadyI = '1;
    inValidI = '0;
    opI = '0; rsI = '0; rtI = '0; rdI = '0;
    @(negedge clk);
    setIns(1, 1, 6'b000000, 5'd1, 5'd2, 5'd3);
    repeat (3) tick();
    rst = 1'b0;
    inValidI[1] = 1'b0;
    tick();

    send(1, 6'b000000, 5'd1, 5'd2, 5'd9);
    send(1, 6'b100011, 5'd3, 5'd10, 5'd0);
    send(1, 6'b101011, 5'd4, 5'd11, 5'd0);
    send(1, 6'b000100, 5'd12, 5'd13, 5'd0);
    send(1, 6'b001000, 5'd14, 5'd15, 5'd0);
    send(1, 6'b000101, 5'd16, 5'd17, 5'd0);
    send(1, 6'b000010, 5'd0, 5'd0, 5'd0);
    tick();

    send(1, 6'b100011, 5'd1, 5'd5, 5'd0);
    send(1, 6'b000000, 5'd5, 5'd6, 5'd7);
    repeat (2) tick();
    send(1, 6'b100011, 5'd1, 5'd0, 5'd0);
    send(1, 6'b000000, 5'd0, 5'd0, 5'd8);
    tick();

    send(1, 6'b101011, 5'd2, 5'd3, 5'd0);
    outReadyI[1] = 1'b0;
    setIns(1, 1, 6'b000000, 5'd4, 5'd5, 5'd6);
    repeat (4) tick();
    outReadyI[1] = 1'b1;
    send(1, 6'b000000, 5'd4, 5'd5, 5'd6);
    tick();

    send(1, 6'b100011, 5'd1, 5'd7, 5'd0);
    setIns(1, 1, 6'b000000, 5'd7, 5'd2, 5'd3);
    flushI[1] = 1'b1;
    tick();
    flushI[1] = 1'b0;
    inValidI[1] = 1'b0;
    repeat (2) tick();

    send(0, 6'b001000, 5'd1, 5'd2, 5'd0);
    for (int n = 0; n < 300; n++) send(0, 6'b111111, 5'd1, 5'd2, 5'd3);
    tick();

    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!(inValidI[i] && !lastAcc[i])) begin
          bit [5:0] op;
          op = ($urandom_range(0, 7) == 0) ? 6'($urandom)
                                            : legalOps[$urandom_range(0, 6)];
          setIns(i, $urandom_range(0, 9) < 8, op,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)));
        end
        flushI[i]    = ($urandom_range(0, 99) < 6);
        outReadyI[i] = ($urandom_range(0, 9) < 7);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
